l2_icache_read: RTL and testbench
=================================

Name: l2_icache_read

Overview:
- Read-only, direct-mapped L2 instruction cache directly downstream of the L1 instruction-read cache.
- Receives L1 read misses and answers in the same cycle on an L2 hit with the requested word and the full 128-bit line for L1 refill.
- On an L2 miss it fetches the line from main memory through a req/ready handshake, fills it, and hits on the following cycle.

Parameters:
- L2_INDEX_W, 5, index bits; L2 holds 2^L2_INDEX_W lines of 128 bits.
- ADDR_W, 30, word-address width from L1.
- TAG_W, ADDR_W-2-L2_INDEX_W (default 23), stored tag width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- proc_reset_n  in  1  asynchronous, active-low reset.
- L1_read_miss_I  in  1  L1 miss request; held high while L1 stalls.
- L2_addr_I  in  30  word address of the request; stable while L1_read_miss_I is high.
- L2_read_hit_I  out  1  combinational hit indication to L1.
- L2_rdata_I  out  32  requested word; valid while L2_read_hit_I is high.
- mem_rdata_I  out  128  whole L2 line for the L1 fill; valid while L2_read_hit_I is high.
- L2_ready_I  out  1  one-cycle pulse, registered, on the cycle after a memory fill is written.
- mem_read  out  1  memory read request, registered.
- mem_addr  out  28  memory line address, registered.
- mem_rdata  in  128  memory line data; sampled when mem_ready is high.
- mem_ready  in  1  memory data-valid; may arrive any number of cycles (≥1) after mem_read rises.

Behaviour:
- Address split:
  - word = L2_addr_I[1:0]
  - index = L2_addr_I[1+L2_INDEX_W:2]
  - tag = L2_addr_I[29:2+L2_INDEX_W]
- Word lane mapping, matching the L1 line format:
  - word 0 = line[31:0]
  - word 1 = line[63:32]
  - word 2 = line[95:64]
  - word 3 = line[127:96]
- Storage per line: valid bit, TAG_W tag, 128-bit data. No dirty bit; the cache is read-only.
- Lookup is combinational from registered storage: hit = L1_read_miss_I & valid[index] & (tag_store[index] == tag) & (state == IDLE).
- On hit:
  - L2_read_hit_I = 1.
  - L2_rdata_I = selected word.
  - mem_rdata_I = line.
  - Zero added latency.
- When not hit, L2_read_hit_I = 0, L2_rdata_I = 0, mem_rdata_I = 0.
- FSM states: IDLE, MEM_REQ, FILL.
  - IDLE:
    - L1_read_miss_I & !hit -> MEM_REQ.
    - Latch miss_index and miss_tag.
    - Register mem_addr = L2_addr_I[29:2] and mem_read = 1.
  - MEM_REQ:
    - mem_read held at 1 and mem_addr held stable until mem_ready.
    - On mem_ready, at that edge:
      - Write mem_rdata into line[miss_index], set tag = miss_tag, valid = 1.
      - mem_read = 0.
      - -> FILL.
  - FILL:
    - L2_ready_I = 1 for this cycle only; -> IDLE.
    - Lookup is suppressed; hit is evaluated again next cycle in IDLE.
- Miss-to-hit latency: the request cycle, then N cycles in MEM_REQ (until mem_ready), then 1 FILL cycle, then the hit in the next IDLE cycle.
- Fill is written using the latched index/tag, never the live address.
- If L1_read_miss_I drops or L2_addr_I changes during MEM_REQ, the fetch still completes and fills the latched line. No abort.
- mem_ready while in IDLE or FILL is ignored.
- A conflict miss overwrites the resident line unconditionally; no writeback.
- Asynchronous reset (proc_reset_n = 0), including mid-MEM_REQ:
  - All valid bits = 0; state = IDLE.
  - mem_read = 0, mem_addr = 0, L2_ready_I = 0.
  - Latched index/tag = 0.
  - Tag/data storage need not be cleared.
- After reset: L2_read_hit_I = 0, L2_rdata_I = 0, mem_rdata_I = 0 until a fill occurs.
- A memory response arriving after reset is ignored.

Test Plan:
- Cold miss:
  - Stimulus: reset, then L1_read_miss_I = 1, L2_addr_I = 30'h0000_0045; mem_ready 3 cycles later with mem_rdata = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA.
  - Required: mem_read = 1 with mem_addr = 28'h000_0011 until mem_ready; L2_ready_I pulses once; next cycle L2_read_hit_I = 1, L2_rdata_I = 32'hBBBB_BBBB, mem_rdata_I equals the full line.
- Hit all words:
  - Stimulus: after the fill, L2_addr_I = 0x44, 0x45, 0x46, 0x47.
  - Required: same-cycle hits returning AAAA_AAAA, BBBB_BBBB, CCCC_CCCC, DDDD_DDDD; mem_read stays 0.
- Conflict eviction:
  - Stimulus: miss to 30'h0000_00C5 (same index 17, different tag), filled with 128'h1111…_4444.
  - Required: subsequent request to 0x45 misses again and mem_read rises with mem_addr = 28'h000_0011.
- Request withdrawn:
  - Stimulus: drop L1_read_miss_I and change L2_addr_I during MEM_REQ.
  - Required: mem_addr unchanged; fill goes to the latched index; a later request to the original address hits.
- Reset mid-fetch:
  - Stimulus: proc_reset_n low during MEM_REQ, then mem_ready.
  - Required: mem_read = 0 immediately (asynchronously); the line is not filled; a request to the original address misses.
- Long latency:
  - Stimulus: mem_ready delayed 20 cycles.
  - Required: mem_read and mem_addr held stable for all 20 cycles; L2_read_hit_I = 0 throughout.

Source files
------------

// File: rtl/l2_icache_read_if.sv
// l2_icache_read_if: bundles the L1-facing miss/hit signals and the
// main-memory request/response signals of the L2 instruction cache.
//   L1 side : L1_read_miss_I, L2_addr_I -> L2_read_hit_I, L2_rdata_I,
//             mem_rdata_I, L2_ready_I
//   mem side: mem_read, mem_addr -> mem_rdata, mem_ready
// Modports: slave = the cache, master = the L1 / memory environment.
interface l2_icache_read_if #(
    parameter int ADDR_W = 30
);
    logic              L1_read_miss_I;
    logic [ADDR_W-1:0] L2_addr_I;
    logic              L2_read_hit_I;
    logic [31:0]       L2_rdata_I;
    logic [127:0]      mem_rdata_I;
    logic              L2_ready_I;
    logic              mem_read;
    logic [ADDR_W-3:0] mem_addr;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport slave (
        input  L1_read_miss_I, L2_addr_I, mem_rdata, mem_ready,
        output L2_read_hit_I, L2_rdata_I, mem_rdata_I, L2_ready_I,
               mem_read, mem_addr
    );

    modport master (
        output L1_read_miss_I, L2_addr_I, mem_rdata, mem_ready,
        input  L2_read_hit_I, L2_rdata_I, mem_rdata_I, L2_ready_I,
               mem_read, mem_addr
    );
endinterface

// File: rtl/l2_icache_read.sv
// l2_icache_read: read-only, direct-mapped L2 instruction cache behind the
// L1 instruction cache. Hits are answered combinationally with the word and
// the full 128-bit line; misses fetch the line from memory via mem_read /
// mem_ready, fill it, and hit on the cycle after the FILL pulse.
// Ports:
//   clk          - rising-edge clock
//   proc_reset_n - asynchronous active-low reset
//   bus          - l2_icache_read_if.slave (L1 request/response + memory)
module l2_icache_read #(
    parameter int L2_INDEX_W = 5,
    parameter int ADDR_W     = 30,
    parameter int TAG_W      = ADDR_W - 2 - L2_INDEX_W
) (
    input  logic                   clk,
    input  logic                   proc_reset_n,
    l2_icache_read_if.slave        bus
);
    localparam int LINES = 2 ** L2_INDEX_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEM_REQ = 2'd1;
    localparam logic [1:0] FILL    = 2'd2;

    logic [1:0]            state;
    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_store  [LINES];
    logic [127:0]          data_store [LINES];
    logic [L2_INDEX_W-1:0] miss_index;
    logic [TAG_W-1:0]      miss_tag;

    logic [1:0]            req_word;
    logic [L2_INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [127:0]          req_line;
    logic                  hit;
    logic                  fill_now;

    assign req_word  = bus.L2_addr_I[1:0];
    assign req_index = bus.L2_addr_I[2 +: L2_INDEX_W];
    assign req_tag   = bus.L2_addr_I[ADDR_W-1 -: TAG_W];
    assign req_line  = data_store[req_index];

    // Lookup only in IDLE; FILL deliberately reports a miss for one cycle.
    assign hit = bus.L1_read_miss_I & valid[req_index] &
                 (tag_store[req_index] == req_tag) & (state == IDLE);

    assign fill_now = (state == MEM_REQ) & bus.mem_ready;

    always_comb begin
        bus.L2_rdata_I = '0;
        if (hit) begin
            case (req_word)
                2'd0:    bus.L2_rdata_I = req_line[31:0];
                2'd1:    bus.L2_rdata_I = req_line[63:32];
                2'd2:    bus.L2_rdata_I = req_line[95:64];
                default: bus.L2_rdata_I = req_line[127:96];
            endcase
        end
    end

    assign bus.L2_read_hit_I = hit;
    assign bus.mem_rdata_I   = hit ? req_line : '0;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state          <= IDLE;
            valid          <= '0;
            miss_index     <= '0;
            miss_tag       <= '0;
            bus.mem_read   <= 1'b0;
            bus.mem_addr   <= '0;
            bus.L2_ready_I <= 1'b0;
        end else begin
            bus.L2_ready_I <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.L1_read_miss_I && !hit) begin
                        state        <= MEM_REQ;
                        miss_index   <= req_index;
                        miss_tag     <= req_tag;
                        bus.mem_addr <= bus.L2_addr_I[ADDR_W-1:2];
                        bus.mem_read <= 1'b1;
                    end
                end
                MEM_REQ: begin
                    if (bus.mem_ready) begin
                        valid[miss_index] <= 1'b1;
                        bus.mem_read      <= 1'b0;
                        bus.L2_ready_I    <= 1'b1;
                        state             <= FILL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity alone gates their use. A reset
    // mid-fetch forces state to IDLE before the next edge, so no fill occurs.
    always_ff @(posedge clk) begin
        if (fill_now) begin
            data_store[miss_index] <= bus.mem_rdata;
            tag_store[miss_index]  <= miss_tag;
        end
    end
endmodule

// File: tb/tb_l2_icache_read.sv
module tb_l2_icache_read;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    l2_icache_read_if #(.ADDR_W(30)) bus ();

    l2_icache_read #(.L2_INDEX_W(5), .ADDR_W(30)) dut (
        .clk          (clk),
        .proc_reset_n (rst_n),
        .bus          (bus)
    );

    // Reference model: each index remembers which full line address it holds.
    bit           m_valid [32];
    logic [27:0]  m_laddr [32];
    logic [127:0] m_line  [32];

    function automatic bit m_hit(input logic [29:0] a);
        return m_valid[a[6:2]] && (m_laddr[a[6:2]] == a[29:2]);
    endfunction

    function automatic logic [31:0] m_word(input logic [29:0] a);
        logic [127:0] l = m_line[a[6:2]];
        return 32'(l >> (32 * int'(a[1:0])));
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    endtask

    task automatic rand_line(output logic [127:0] l);
        l = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Full miss transaction with memory answering 'delay' cycles after the request.
    task automatic run_miss(input logic [29:0] a, input int delay, input logic [127:0] line);
        @(negedge clk);
        bus.L1_read_miss_I = 1'b1;
        bus.L2_addr_I      = a;
        #1;
        tests++;
        if (bus.L2_read_hit_I !== 1'b0 || bus.mem_read !== 1'b0) begin
            fails++;
            $display("FAIL miss_detect addr=%h hit=%b mem_read=%b required hit=0 mem_read=0",
                     a, bus.L2_read_hit_I, bus.mem_read);
        end
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            #1;
            tests++;
            if (bus.mem_read !== 1'b1 || bus.mem_addr !== a[29:2] || bus.L2_read_hit_I !== 1'b0) begin
                fails++;
                $display("FAIL mem_req_hold cyc=%0d mem_read=%b mem_addr=%h hit=%b required 1 %h 0",
                         k, bus.mem_read, bus.mem_addr, bus.L2_read_hit_I, a[29:2]);
            end
            if (k == delay - 1) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = line;
            end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        tests++;
        if (bus.L2_ready_I !== 1'b1 || bus.L2_read_hit_I !== 1'b0 || bus.mem_read !== 1'b0) begin
            fails++;
            $display("FAIL fill_pulse ready=%b hit=%b mem_read=%b required 1 0 0",
                     bus.L2_ready_I, bus.L2_read_hit_I, bus.mem_read);
        end
        m_valid[a[6:2]] = 1'b1;
        m_laddr[a[6:2]] = a[29:2];
        m_line[a[6:2]]  = line;
        @(negedge clk);
        #1;
        tests++;
        if (bus.L2_ready_I !== 1'b0 || bus.L2_read_hit_I !== 1'b1 ||
            bus.L2_rdata_I !== m_word(a) || bus.mem_rdata_I !== line) begin
            fails++;
            $display("FAIL post_fill_hit ready=%b hit=%b rdata=%h line=%h required 0 1 %h %h",
                     bus.L2_ready_I, bus.L2_read_hit_I, bus.L2_rdata_I, bus.mem_rdata_I,
                     m_word(a), line);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.L1_read_miss_I = 1'b1;
        bus.L2_addr_I = 30'h45;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        m_clear();
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (bus.L2_read_hit_I !== 1'b0 || bus.L2_rdata_I !== 32'h0 || bus.mem_rdata_I !== 128'h0 ||
            bus.mem_read !== 1'b0 || bus.mem_addr !== 28'h0 || bus.L2_ready_I !== 1'b0) begin
            fails++;
            $display("FAIL reset_state hit=%b rdata=%h line=%h mem_read=%b mem_addr=%h ready=%b required all 0",
                     bus.L2_read_hit_I, bus.L2_rdata_I, bus.mem_rdata_I, bus.mem_read,
                     bus.mem_addr, bus.L2_ready_I);
        end
        bus.L1_read_miss_I = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        run_miss(30'h45, 3, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
        tests++;
        if (bus.L2_rdata_I !== 32'hBBBB_BBBB) begin
            fails++;
            $display("FAIL cold_miss_word rdata=%h required BBBBBBBB", bus.L2_rdata_I);
        end
    endtask

    task automatic test_hit_all_words();
        logic [31:0] exp_w [4] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            bus.L1_read_miss_I = 1'b1;
            bus.L2_addr_I = 30'h44 + 30'(w);
            #1;
            tests++;
            if (bus.L2_read_hit_I !== 1'b1 || bus.L2_rdata_I !== exp_w[w] || bus.mem_read !== 1'b0) begin
                fails++;
                $display("FAIL hit_word%0d hit=%b rdata=%h mem_read=%b required 1 %h 0",
                         w, bus.L2_read_hit_I, bus.L2_rdata_I, bus.mem_read, exp_w[w]);
            end
        end
    endtask

    task automatic test_conflict_eviction();
        run_miss(30'hC5, 2, 128'h1111_1111_2222_2222_3333_3333_4444_4444);
        run_miss(30'h45, 2, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
    endtask

    task automatic test_request_withdrawn();
        logic [29:0]  a = 30'h0001_2368;
        logic [127:0] line;
        rand_line(line);
        @(negedge clk);
        bus.L1_read_miss_I = 1'b1;
        bus.L2_addr_I = a;
        @(negedge clk);
        bus.L1_read_miss_I = 1'b0;
        bus.L2_addr_I = 30'h3FFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            tests++;
            if (bus.mem_read !== 1'b1 || bus.mem_addr !== a[29:2]) begin
                fails++;
                $display("FAIL withdrawn_hold cyc=%0d mem_read=%b mem_addr=%h required 1 %h",
                         k, bus.mem_read, bus.mem_addr, a[29:2]);
            end
            if (k == 3) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = line;
            end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        m_valid[a[6:2]] = 1'b1;
        m_laddr[a[6:2]] = a[29:2];
        m_line[a[6:2]]  = line;
        @(negedge clk);
        bus.L1_read_miss_I = 1'b1;
        bus.L2_addr_I = a;
        #1;
        tests++;
        if (bus.L2_read_hit_I !== 1'b1 || bus.mem_rdata_I !== line || bus.L2_rdata_I !== m_word(a)) begin
            fails++;
            $display("FAIL withdrawn_fill hit=%b line=%h rdata=%h required 1 %h %h",
                     bus.L2_read_hit_I, bus.mem_rdata_I, bus.L2_rdata_I, line, m_word(a));
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [29:0]  a = 30'h0000_0A7B;
        logic [127:0] line;
        rand_line(line);
        @(negedge clk);
        bus.L1_read_miss_I = 1'b1;
        bus.L2_addr_I = a;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.mem_read !== 1'b0 || bus.mem_addr !== 28'h0 || bus.L2_read_hit_I !== 1'b0) begin
            fails++;
            $display("FAIL reset_async mem_read=%b mem_addr=%h hit=%b required 0 0 0",
                     bus.mem_read, bus.mem_addr, bus.L2_read_hit_I);
        end
        m_clear();
        bus.L1_read_miss_I = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = line;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        tests++;
        if (bus.L2_ready_I !== 1'b0 || bus.mem_read !== 1'b0) begin
            fails++;
            $display("FAIL late_response ready=%b mem_read=%b required 0 0", bus.L2_ready_I, bus.mem_read);
        end
        run_miss(a, 2, line);
        run_miss(30'h45, 1, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
    endtask

    task automatic test_long_latency();
        logic [127:0] line;
        rand_line(line);
        run_miss(30'h2345_6789, 20, line);
    endtask

    task automatic test_idle_mem_ready();
        @(negedge clk);
        bus.L1_read_miss_I = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = '1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.L1_read_miss_I = 1'b1;
        bus.L2_addr_I = 30'h46;
        #1;
        tests++;
        if (bus.L2_ready_I !== 1'b0 || bus.L2_read_hit_I !== 1'b1 || bus.L2_rdata_I !== m_word(30'h46)) begin
            fails++;
            $display("FAIL idle_ready_ignored ready=%b hit=%b rdata=%h required 0 1 %h",
                     bus.L2_ready_I, bus.L2_read_hit_I, bus.L2_rdata_I, m_word(30'h46));
        end
    endtask

    task automatic test_random();
        logic [29:0]  a;
        logic [127:0] line;
        for (int n = 0; n < 60; n++) begin
            a = {$urandom_range(2, 0) == 0 ? 23'h0 : 23'($urandom_range(2, 1) * 23'h1357),
                 5'($urandom_range(3, 0)), 2'($urandom_range(3, 0))};
            if ($urandom_range(5, 0) == 0) begin
                @(negedge clk);
                bus.L1_read_miss_I = 1'b0;
                bus.L2_addr_I = a;
                #1;
                tests++;
                if (bus.L2_read_hit_I !== 1'b0 || bus.L2_rdata_I !== 32'h0 || bus.mem_rdata_I !== 128'h0) begin
                    fails++;
                    $display("FAIL rand_idle addr=%h hit=%b rdata=%h required 0 0", a,
                             bus.L2_read_hit_I, bus.L2_rdata_I);
                end
            end else if (m_hit(a)) begin
                @(negedge clk);
                bus.L1_read_miss_I = 1'b1;
                bus.L2_addr_I = a;
                #1;
                tests++;
                if (bus.L2_read_hit_I !== 1'b1 || bus.L2_rdata_I !== m_word(a) ||
                    bus.mem_rdata_I !== m_line[a[6:2]] || bus.mem_read !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_hit addr=%h hit=%b rdata=%h mem_read=%b required 1 %h 0",
                             a, bus.L2_read_hit_I, bus.L2_rdata_I, bus.mem_read, m_word(a));
                end
            end else begin
                rand_line(line);
                run_miss(a, int'($urandom_range(5, 1)), line);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_all_words();
        test_conflict_eviction();
        test_request_withdrawn();
        test_reset_mid_fetch();
        test_long_latency();
        test_idle_mem_ready();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
